// File: rtl/alu_reservation_station_pkg.sv
// Shared types and constants for the ALU reservation station slice.
package alu_reservation_station_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned ROB_ID_WIDTH = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [4:0] {
    OP_ENUM_RESET = 5'd0,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_SLT,
    OP_SLTU,
    OP_ADDI,
    OP_ANDI,
    OP_ORI,
    OP_XORI,
    OP_SLLI,
    OP_SRLI,
    OP_SRAI,
    OP_SLTI,
    OP_SLTIU,
    OP_LUI,
    OP_AUIPC,
    OP_BEQ,
    OP_BNE,
    OP_BLT,
    OP_BGE,
    OP_BLTU,
    OP_BGEU,
    OP_JAL,
    OP_JALR
  } op_enum_t;

  localparam data_t DATA_RESET = '0;
  localparam addr_t ADDR_RESET = '0;

endpackage

// File: rtl/alu_reservation_station_rs_priority_pick.sv
// Lowest-index finder: one-hot and binary index of the first set request bit.
module rs_priority_pick #(
  parameter int unsigned DEPTH = 16
) (
  input  logic [DEPTH-1:0]         req,
  output logic [DEPTH-1:0]         onehot,
  output logic [$clog2(DEPTH)-1:0] index
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic found;

  always_comb begin
    found  = 1'b0;
    onehot = '0;
    index  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (req[i] && !found) begin
        found     = 1'b1;
        onehot[i] = 1'b1;
        index     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU/branch ops, snoops both CDBs,
// and issues the lowest-index ready entry into registered ALU inputs.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ROB_ID_W = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rollback_in,

  input  logic                disp_valid_in,
  input  op_enum_t            disp_op_in,
  input  data_t               disp_v1_in,
  input  data_t               disp_v2_in,
  input  logic                disp_q1_busy_in,
  input  logic                disp_q2_busy_in,
  input  logic [ROB_ID_W-1:0] disp_q1_in,
  input  logic [ROB_ID_W-1:0] disp_q2_in,
  input  data_t               disp_imm_in,
  input  addr_t               disp_pc_in,
  input  logic [ROB_ID_W-1:0] disp_rob_in,
  output logic                rs_full_out,

  input  logic                alu_cdb_valid_in,
  input  logic [ROB_ID_W-1:0] alu_cdb_rob_in,
  input  data_t               alu_cdb_value_in,
  input  logic                lsb_cdb_valid_in,
  input  logic [ROB_ID_W-1:0] lsb_cdb_rob_in,
  input  data_t               lsb_cdb_value_in,

  output logic                issue_valid_out,
  output op_enum_t            issue_op_out,
  output data_t               issue_v1_out,
  output data_t               issue_v2_out,
  output data_t               issue_imm_out,
  output addr_t               issue_pc_out,
  output logic [ROB_ID_W-1:0] issue_rob_out
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    q1_busy;
  logic [DEPTH-1:0]    q2_busy;
  op_enum_t            op_q  [DEPTH];
  data_t               v1_q  [DEPTH];
  data_t               v2_q  [DEPTH];
  data_t               imm_q [DEPTH];
  addr_t               pc_q  [DEPTH];
  logic [ROB_ID_W-1:0] q1_q  [DEPTH];
  logic [ROB_ID_W-1:0] q2_q  [DEPTH];
  logic [ROB_ID_W-1:0] rob_q [DEPTH];

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] sel_oh;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             free_found;
  logic             sel_found;

  assign ready       = busy & ~q1_busy & ~q2_busy;
  assign rs_full_out = &busy;
  assign free_found  = |free_oh;
  assign sel_found   = |sel_oh;

  rs_priority_pick #(.DEPTH(DEPTH)) u_alloc_pick (
    .req    (~busy),
    .onehot (free_oh),
    .index  (free_idx)
  );

  rs_priority_pick #(.DEPTH(DEPTH)) u_issue_pick (
    .req    (ready),
    .onehot (sel_oh),
    .index  (sel_idx)
  );

  // Operand capture at dispatch: a same-cycle broadcast of the producer tag is
  // taken directly, with the ALU CDB taking precedence over the LSB CDB.
  data_t d_v1, d_v2;
  logic  d_q1_busy, d_q2_busy;

  always_comb begin
    d_v1      = disp_v1_in;
    d_q1_busy = disp_q1_busy_in;
    d_v2      = disp_v2_in;
    d_q2_busy = disp_q2_busy_in;
    if (disp_q1_busy_in) begin
      if (alu_cdb_valid_in && alu_cdb_rob_in == disp_q1_in) begin
        d_v1      = alu_cdb_value_in;
        d_q1_busy = FALSE;
      end else if (lsb_cdb_valid_in && lsb_cdb_rob_in == disp_q1_in) begin
        d_v1      = lsb_cdb_value_in;
        d_q1_busy = FALSE;
      end
    end
    if (disp_q2_busy_in) begin
      if (alu_cdb_valid_in && alu_cdb_rob_in == disp_q2_in) begin
        d_v2      = alu_cdb_value_in;
        d_q2_busy = FALSE;
      end else if (lsb_cdb_valid_in && lsb_cdb_rob_in == disp_q2_in) begin
        d_v2      = lsb_cdb_value_in;
        d_q2_busy = FALSE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy            <= '0;
      q1_busy         <= '0;
      q2_busy         <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]  <= OP_ENUM_RESET;
        v1_q[i]  <= DATA_RESET;
        v2_q[i]  <= DATA_RESET;
        imm_q[i] <= DATA_RESET;
        pc_q[i]  <= ADDR_RESET;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        rob_q[i] <= '0;
      end
      issue_valid_out <= FALSE;
      issue_op_out    <= OP_ENUM_RESET;
      issue_v1_out    <= DATA_RESET;
      issue_v2_out    <= DATA_RESET;
      issue_imm_out   <= DATA_RESET;
      issue_pc_out    <= ADDR_RESET;
      issue_rob_out   <= '0;
    end else if (rollback_in) begin
      busy            <= '0;
      issue_valid_out <= FALSE;
    end else if (!rdy_in) begin
      issue_valid_out <= FALSE;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (busy[i] && q1_busy[i]) begin
          if (alu_cdb_valid_in && alu_cdb_rob_in == q1_q[i]) begin
            v1_q[i]    <= alu_cdb_value_in;
            q1_busy[i] <= FALSE;
          end else if (lsb_cdb_valid_in && lsb_cdb_rob_in == q1_q[i]) begin
            v1_q[i]    <= lsb_cdb_value_in;
            q1_busy[i] <= FALSE;
          end
        end
        if (busy[i] && q2_busy[i]) begin
          if (alu_cdb_valid_in && alu_cdb_rob_in == q2_q[i]) begin
            v2_q[i]    <= alu_cdb_value_in;
            q2_busy[i] <= FALSE;
          end else if (lsb_cdb_valid_in && lsb_cdb_rob_in == q2_q[i]) begin
            v2_q[i]    <= lsb_cdb_value_in;
            q2_busy[i] <= FALSE;
          end
        end
      end

      if (sel_found) begin
        busy[sel_idx]   <= FALSE;
        issue_valid_out <= TRUE;
        issue_op_out    <= op_q[sel_idx];
        issue_v1_out    <= v1_q[sel_idx];
        issue_v2_out    <= v2_q[sel_idx];
        issue_imm_out   <= imm_q[sel_idx];
        issue_pc_out    <= pc_q[sel_idx];
        issue_rob_out   <= rob_q[sel_idx];
      end else begin
        issue_valid_out <= FALSE;
      end

      // The allocated slot is free, so it never collides with wakeup or issue.
      if (disp_valid_in && free_found) begin
        busy[free_idx]    <= TRUE;
        op_q[free_idx]    <= disp_op_in;
        v1_q[free_idx]    <= d_v1;
        v2_q[free_idx]    <= d_v2;
        q1_busy[free_idx] <= d_q1_busy;
        q2_busy[free_idx] <= d_q2_busy;
        q1_q[free_idx]    <= disp_q1_in;
        q2_q[free_idx]    <= disp_q2_in;
        imm_q[free_idx]   <= disp_imm_in;
        pc_q[free_idx]    <= disp_pc_in;
        rob_q[free_idx]   <= disp_rob_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with hand-computed expectations.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rollback_in = 1'b0;
  logic        disp_valid_in = 1'b0;
  op_enum_t    disp_op_in = OP_ENUM_RESET;
  data_t       disp_v1_in = '0;
  data_t       disp_v2_in = '0;
  logic        disp_q1_busy_in = 1'b0;
  logic        disp_q2_busy_in = 1'b0;
  logic [3:0]  disp_q1_in = '0;
  logic [3:0]  disp_q2_in = '0;
  data_t       disp_imm_in = '0;
  addr_t       disp_pc_in = '0;
  logic [3:0]  disp_rob_in = '0;
  logic        rs_full_out;
  logic        alu_cdb_valid_in = 1'b0;
  logic [3:0]  alu_cdb_rob_in = '0;
  data_t       alu_cdb_value_in = '0;
  logic        lsb_cdb_valid_in = 1'b0;
  logic [3:0]  lsb_cdb_rob_in = '0;
  data_t       lsb_cdb_value_in = '0;
  logic        issue_valid_out;
  op_enum_t    issue_op_out;
  data_t       issue_v1_out;
  data_t       issue_v2_out;
  data_t       issue_imm_out;
  addr_t       issue_pc_out;
  logic [3:0]  issue_rob_out;

  int n_cmp = 0;
  int n_err = 0;

  alu_reservation_station #(.DEPTH(16), .ROB_ID_W(4)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .rollback_in      (rollback_in),
    .disp_valid_in    (disp_valid_in),
    .disp_op_in       (disp_op_in),
    .disp_v1_in       (disp_v1_in),
    .disp_v2_in       (disp_v2_in),
    .disp_q1_busy_in  (disp_q1_busy_in),
    .disp_q2_busy_in  (disp_q2_busy_in),
    .disp_q1_in       (disp_q1_in),
    .disp_q2_in       (disp_q2_in),
    .disp_imm_in      (disp_imm_in),
    .disp_pc_in       (disp_pc_in),
    .disp_rob_in      (disp_rob_in),
    .rs_full_out      (rs_full_out),
    .alu_cdb_valid_in (alu_cdb_valid_in),
    .alu_cdb_rob_in   (alu_cdb_rob_in),
    .alu_cdb_value_in (alu_cdb_value_in),
    .lsb_cdb_valid_in (lsb_cdb_valid_in),
    .lsb_cdb_rob_in   (lsb_cdb_rob_in),
    .lsb_cdb_value_in (lsb_cdb_value_in),
    .issue_valid_out  (issue_valid_out),
    .issue_op_out     (issue_op_out),
    .issue_v1_out     (issue_v1_out),
    .issue_v2_out     (issue_v2_out),
    .issue_imm_out    (issue_imm_out),
    .issue_pc_out     (issue_pc_out),
    .issue_rob_out    (issue_rob_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    disp_valid_in    = 1'b0;
    alu_cdb_valid_in = 1'b0;
    lsb_cdb_valid_in = 1'b0;
  endtask

  task automatic dispatch(input op_enum_t op, input data_t v1, input logic q1b, input logic [3:0] q1,
                          input data_t v2, input logic q2b, input logic [3:0] q2,
                          input data_t imm, input addr_t pc, input logic [3:0] rob);
    disp_valid_in   = 1'b1;
    disp_op_in      = op;
    disp_v1_in      = v1;
    disp_q1_busy_in = q1b;
    disp_q1_in      = q1;
    disp_v2_in      = v2;
    disp_q2_busy_in = q2b;
    disp_q2_in      = q2;
    disp_imm_in     = imm;
    disp_pc_in      = pc;
    disp_rob_in     = rob;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 32'(issue_valid_out), 32'd0);
    check("rst_full",  32'(rs_full_out), 32'd0);
    check("rst_op",    32'(issue_op_out), 32'(OP_ENUM_RESET));
    check("rst_v1",    issue_v1_out, 32'd0);
    check("rst_rob",   32'(issue_rob_out), 32'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    tick();

    // Basic ADD, 2-cycle latency
    dispatch(OP_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'd0, 32'h100, 4'd3);
    tick();
    idle();
    check("add_not_yet", 32'(issue_valid_out), 32'd0);
    tick();
    check("add_valid", 32'(issue_valid_out), 32'd1);
    check("add_op",    32'(issue_op_out), 32'(OP_ADD));
    check("add_v1",    issue_v1_out, 32'd5);
    check("add_v2",    issue_v2_out, 32'd7);
    check("add_pc",    issue_pc_out, 32'h100);
    check("add_rob",   32'(issue_rob_out), 32'd3);
    tick();
    check("add_after", 32'(issue_valid_out), 32'd0);

    // ADDI waits on LSB CDB
    dispatch(OP_ADDI, 32'd0, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'h20, 32'h104, 4'd2);
    tick();
    idle();
    tick();
    check("addi_wait", 32'(issue_valid_out), 32'd0);
    lsb_cdb_valid_in = 1'b1; lsb_cdb_rob_in = 4'd1; lsb_cdb_value_in = 32'h10;
    tick();
    idle();
    check("addi_capture_edge", 32'(issue_valid_out), 32'd0);
    tick();
    check("addi_valid", 32'(issue_valid_out), 32'd1);
    check("addi_v1",    issue_v1_out, 32'h10);
    check("addi_imm",   issue_imm_out, 32'h20);
    check("addi_rob",   32'(issue_rob_out), 32'd2);
    tick();
    check("addi_after", 32'(issue_valid_out), 32'd0);

    // Same-cycle capture at dispatch, ALU CDB beats LSB CDB
    dispatch(OP_SUB, 32'd0, 1'b1, 4'd4, 32'd1, 1'b0, 4'd0, 32'd0, 32'h108, 4'd5);
    alu_cdb_valid_in = 1'b1; alu_cdb_rob_in = 4'd4; alu_cdb_value_in = 32'd9;
    lsb_cdb_valid_in = 1'b1; lsb_cdb_rob_in = 4'd4; lsb_cdb_value_in = 32'd99;
    tick();
    idle();
    tick();
    check("cap_valid", 32'(issue_valid_out), 32'd1);
    check("cap_v1",    issue_v1_out, 32'd9);
    check("cap_rob",   32'(issue_rob_out), 32'd5);
    tick();

    // Fill all entries; entry i waits on tag i
    for (int i = 0; i < 16; i++) begin
      dispatch(OP_XOR, 32'd0, 1'b1, 4'(i), 32'd0, 1'b0, 4'd0, 32'd0, 32'(i * 4), 4'(i));
      tick();
      if (i == 14) check("fill15_full", 32'(rs_full_out), 32'd0);
    end
    idle();
    check("fill_full", 32'(rs_full_out), 32'd1);
    check("fill_noissue", 32'(issue_valid_out), 32'd0);
    alu_cdb_valid_in = 1'b1; alu_cdb_rob_in = 4'd6; alu_cdb_value_in = 32'h77;
    tick();
    idle();
    check("wake_full", 32'(rs_full_out), 32'd1);
    check("wake_noissue", 32'(issue_valid_out), 32'd0);
    tick();
    check("fill_issue_valid", 32'(issue_valid_out), 32'd1);
    check("fill_issue_rob",   32'(issue_rob_out), 32'd6);
    check("fill_issue_v1",    issue_v1_out, 32'h77);
    check("fill_issue_pc",    issue_pc_out, 32'd24);
    check("freed_full",       32'(rs_full_out), 32'd0);
    dispatch(OP_OR, 32'h66, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h200, 4'hA);
    tick();
    idle();
    check("refill_full", 32'(rs_full_out), 32'd1);
    check("refill_gap",  32'(issue_valid_out), 32'd0);
    tick();
    check("refill_valid", 32'(issue_valid_out), 32'd1);
    check("refill_rob",   32'(issue_rob_out), 32'hA);
    check("refill_v1",    issue_v1_out, 32'h66);
    rollback_in = 1'b1;
    tick();
    rollback_in = 1'b0;
    check("flush_full", 32'(rs_full_out), 32'd0);

    // Indices 0, 5, 9 wake together and issue in index order
    for (int i = 0; i < 10; i++) begin
      dispatch(OP_AND, 32'd0, 1'b1, (i == 0 || i == 5 || i == 9) ? 4'hE : 4'hF,
               32'd3, 1'b0, 4'd0, 32'd0, 32'h300, 4'(i));
      tick();
    end
    idle();
    alu_cdb_valid_in = 1'b1; alu_cdb_rob_in = 4'hE; alu_cdb_value_in = 32'h55;
    tick();
    idle();
    check("multi_gap", 32'(issue_valid_out), 32'd0);
    tick();
    check("multi_rob0", 32'(issue_rob_out), 32'd0);
    check("multi_v0",   32'(issue_valid_out), 32'd1);
    tick();
    check("multi_rob5", 32'(issue_rob_out), 32'd5);
    check("multi_v1_5", issue_v1_out, 32'h55);
    tick();
    check("multi_rob9", 32'(issue_rob_out), 32'd9);
    check("multi_v9",   32'(issue_valid_out), 32'd1);
    tick();
    check("multi_done", 32'(issue_valid_out), 32'd0);
    rollback_in = 1'b1;
    tick();
    rollback_in = 1'b0;

    // Rollback with 4 busy entries, dispatch and wakeup in the same cycle
    for (int i = 0; i < 4; i++) begin
      dispatch(OP_SLT, 32'd0, 1'b1, 4'hF, 32'd0, 1'b0, 4'd0, 32'd0, 32'h400, 4'(i));
      tick();
    end
    dispatch(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd0, 32'h500, 4'hC);
    alu_cdb_valid_in = 1'b1; alu_cdb_rob_in = 4'hF; alu_cdb_value_in = 32'h1;
    rollback_in = 1'b1;
    tick();
    rollback_in = 1'b0;
    idle();
    check("rb_valid", 32'(issue_valid_out), 32'd0);
    check("rb_full",  32'(rs_full_out), 32'd0);
    tick();
    check("rb_no_dispatch", 32'(issue_valid_out), 32'd0);
    alu_cdb_valid_in = 1'b1; alu_cdb_rob_in = 4'hF; alu_cdb_value_in = 32'h1;
    tick();
    idle();
    tick();
    check("rb_no_wake_a", 32'(issue_valid_out), 32'd0);
    tick();
    check("rb_no_wake_b", 32'(issue_valid_out), 32'd0);

    // Pause: ready entry waits while rdy_in is low; dispatch during pause ignored
    dispatch(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'h600, 4'hB);
    tick();
    rdy_in = 1'b0;
    dispatch(OP_ADD, 32'd2, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd0, 32'h604, 4'hD);
    tick();
    check("pause_a", 32'(issue_valid_out), 32'd0);
    tick();
    check("pause_b", 32'(issue_valid_out), 32'd0);
    idle();
    rdy_in = 1'b1;
    tick();
    check("resume_valid", 32'(issue_valid_out), 32'd1);
    check("resume_rob",   32'(issue_rob_out), 32'hB);
    tick();
    check("pause_ignored", 32'(issue_valid_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Reservation station for the out-of-order core's ALU path. It buffers decoded ALU/branch/jump instructions from the dispatcher and captures operands from the two common data buses (ALU CDB and LSB CDB). It issues one operand-ready instruction per cycle as registered inputs to the combinational ALU, and the ALU result plus this block's issued ROB tag form the ALU CDB. It is the initiator side of the ALU operand interface.

## Interface
- DEPTH, 16: number of entries (power of two, ≥2)
- ROB_ID_W, 4: ROB tag width
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global ready; low = pause
- rollback_in  in  1  misprediction flush
- disp_valid_in  in  1  dispatch request
- disp_op_in  in  OP_ENUM width  operation enum
- disp_v1_in / disp_v2_in  in  32  operand values
- disp_q1_busy_in / disp_q2_busy_in  in  1  operand not yet available
- disp_q1_in / disp_q2_in  in  ROB_ID_W  producer tag
- disp_imm_in  in  32  immediate
- disp_pc_in  in  32  instruction address
- disp_rob_in  in  ROB_ID_W  destination ROB tag
- rs_full_out  out  1  no free entry
- alu_cdb_valid_in, alu_cdb_rob_in, alu_cdb_value_in  in  1/ROB_ID_W/32  ALU broadcast
- lsb_cdb_valid_in, lsb_cdb_rob_in, lsb_cdb_value_in  in  1/ROB_ID_W/32  LSB broadcast
- issue_valid_out  out  1  issued instruction present
- issue_op_out, issue_v1_out, issue_v2_out, issue_imm_out, issue_pc_out  out  per field  ALU inputs
- issue_rob_out  out  ROB_ID_W  tag travelling with ALU result

## Operation
- Entry state: busy, op, V1, V2, Q1/Q2 busy flags and tags, imm, pc, rob.
- Allocation: lowest-index entry with busy=0 in registered state. A dispatch while rs_full_out=1 is ignored, and the dispatcher must not present it.
- Dispatch capture: if Qn busy and a valid CDB in the same cycle carries tag Qn, store the CDB value with the flag cleared. If both CDBs match, the ALU CDB wins.
- Wakeup: every busy entry with Qn busy compares its tag against both CDBs each cycle. On a match it stores the value and clears the flag.
- Ready: busy && !Q1 busy && !Q2 busy, evaluated on registered state. Entries woken in this cycle are not ready until the next cycle.
- Select: lowest-index ready entry. That entry's busy bit clears at the edge and its fields load into the issue_* registers with issue_valid_out=1. With no ready entry, issue_valid_out=0 and the other issue_* outputs hold.
- A freed slot is allocatable from the following cycle.
- rs_full_out = all busy bits set (registered state). It covers a slot issuing in the same cycle.
- OP_ENUM_RESET is never dispatched. Unused operands arrive with busy=0.
- rollback_in=1 at an edge:
  - all busy bits and issue_valid_out clear;
  - dispatch and wakeup in that cycle are discarded.
  - Rollback takes priority over rdy_in.
- rdy_in=0 with no rollback: no entry changes, no dispatch accepted, issue_valid_out cleared at the edge.

## Timing
- Reset (rst_in low, asynchronous):
  - all busy bits 0;
  - issue_valid_out 0;
  - issue_* fields 0 (issue_op_out = OP_ENUM_RESET);
  - rs_full_out 0.
- Dispatch with ready operands sampled at edge k → issue_valid_out high after edge k+1. The ALU result appears combinationally in the same cycle. Minimum latency is 2 cycles.
- Dependent wakeup on ALU CDB in cycle after edge j → value captured at edge j+1, issue after edge j+2.
- Throughput: 1 issue per cycle and 1 dispatch per cycle concurrently.

## Structure
- Shared constants package/header holds: OP_ENUM_TYPE/OP_ENUM_RESET, DATA_TYPE, ADDR_TYPE, ROB_ID width, TRUE/FALSE, and reset constants.
- Sub-module rs_priority_pick: parameterised DEPTH-bit lowest-index one-hot/index finder. It is instantiated twice, once for free-slot allocation and once for ready-entry select.
- CDB tag compare is inline per entry.

## Test plan
- Reset, then dispatch ADD rob=3, V1=5, V2=7, both ready → issue_valid_out after 2 edges, op=ADD, V1=5, V2=7, rob=3. Next cycle issue_valid_out=0.
- Dispatch ADDI rob=2 with Q1 busy tag=1. Drive lsb_cdb rob=1, value=0x10 two cycles later → issue one edge after capture, V1=0x10.
- Dispatch with Q1 tag=4 while alu_cdb carries rob=4, value=9 in the same cycle → entry captures 9 and issues 2 edges after dispatch.
- Fill all 16 entries with unready operands → rs_full_out=1 after 16th edge. One wakeup then one issue → rs_full_out=0 after the issuing edge. Next dispatch lands in the freed index.
- Three entries ready simultaneously (indices 0, 5, 9) → issue order 0, 5, 9 on consecutive cycles.
- Assert rollback_in with 4 busy entries and dispatch_valid high → all cleared, nothing issues. Then hold rdy_in=0 with a ready entry → no issue until rdy_in returns to 1.
